// File: rtl/branch_lut_pkg.sv
// Shared types and constants for the branch-target table controller.
// Optional feature macro: BRANCH_LUT_PARITY_EN adds one even-parity bit per table word.
package branch_lut_pkg;

  localparam int BTL_ADDR_W = 8;
  localparam int BTL_DATA_W = 8;

`ifdef BRANCH_LUT_PARITY_EN
  localparam int BTL_PAR_W = 1;
`else
  localparam int BTL_PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } btc_state_t;

endpackage

// File: rtl/branch_lut_ram.sv
// Branch-target storage: one write port, one registered read port.
// A read and a write to the same entry in one cycle return the old contents.
// With BRANCH_LUT_PARITY_EN each word carries an even-parity bit and a sticky
// error flag is raised on the same edge that registers a bad word.
module branch_lut_ram
  import branch_lut_pkg::*;
#(
  parameter int ADDR_W = BTL_ADDR_W,
  parameter int DATA_W = BTL_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              perr
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = DATA_W + BTL_PAR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rword;

`ifdef BRANCH_LUT_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  assign rword = mem[raddr];

  // Table write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rword[DATA_W-1:0];
  end

`ifdef BRANCH_LUT_PARITY_EN
  // Sticky parity error, set when a word with odd parity is read out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                perr <= 1'b0;
    else if (re && ^rword)  perr <= 1'b1;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/branch_target_ctrl.sv
// Branch-target table controller: boot-loads the table from a byte stream,
// zero-fills any unstreamed tail, then serves lookups and single-entry updates.
// Lookups take priority over updates. Optional macro: BRANCH_LUT_PARITY_EN.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  LOAD  | accepting boot stream bytes into table[ptr]; core stalled
//  FILL  | writing zeros from ptr up to the last entry; core stalled
//  RUN   | table live: lookups, runtime updates, reload requests
module branch_target_ctrl
  import branch_lut_pkg::*;
#(
  parameter int ADDR_W = BTL_ADDR_W,
  parameter int DATA_W = BTL_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              busy,
  input  logic              lkp_valid,
  input  logic [ADDR_W-1:0] lkp_index,
  output logic [DATA_W-1:0] branch_addr,
  output logic              addr_valid,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_index,
  input  logic [DATA_W-1:0] upd_data,
  output logic              upd_ready,
  output logic              parity_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  btc_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic              lkp_acc;
  logic              upd_acc;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign busy       = (state != RUN);
  assign load_ready = (state == LOAD);
  assign upd_ready  = (state == RUN) && !lkp_valid;
  assign lkp_acc    = (state == RUN) && lkp_valid;
  // An update presented alongside reload is dropped rather than written.
  assign upd_acc    = upd_valid && upd_ready && !reload;

  // Single write port shared by boot load, zero fill and runtime updates.
  always_comb begin
    we    = 1'b0;
    waddr = ptr;
    wdata = '0;
    unique case (state)
      LOAD: begin
        we    = load_valid;
        wdata = load_data;
      end
      FILL: we = 1'b1;
      RUN: begin
        we    = upd_acc;
        waddr = upd_index;
        wdata = upd_data;
      end
      default: we = 1'b0;
    endcase
  end

  // Sequencing FSM and table pointer; ptr wraps to 0 on entry to RUN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= LOAD;
      ptr   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_valid) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_IDX) state <= RUN;
            else if (load_last)  state <= FILL;
          end
        end
        FILL: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) state <= RUN;
        end
        RUN: begin
          if (reload) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        default: begin
          state <= LOAD;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Result strobe marks the cycle after each accepted lookup.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) addr_valid <= 1'b0;
    else       addr_valid <= lkp_acc;
  end

  branch_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (Clk),
    .rst   (Reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (lkp_acc),
    .raddr (lkp_index),
    .rdata (branch_addr),
    .perr  (parity_err)
  );

endmodule

// File: tb/tb_branch_target_ctrl.sv
// Self-checking bench for branch_target_ctrl against a table-level reference model.
// Honours BRANCH_LUT_PARITY_EN for the parity-corruption scenario.
module tb_branch_target_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_last;
  logic       load_ready;
  logic       reload;
  logic       busy;
  logic       lkp_valid;
  logic [7:0] lkp_index;
  logic [7:0] branch_addr;
  logic       addr_valid;
  logic       upd_valid;
  logic [7:0] upd_index;
  logic [7:0] upd_data;
  logic       upd_ready;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [256];
  logic [7:0] exp_ba;

  always #5 Clk = ~Clk;

  branch_target_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .busy        (busy),
    .lkp_valid   (lkp_valid),
    .lkp_index   (lkp_index),
    .branch_addr (branch_addr),
    .addr_valid  (addr_valid),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_data    (upd_data),
    .upd_ready   (upd_ready),
    .parity_err  (parity_err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream n bytes; model tracks what each table entry must hold afterwards.
  task automatic stream(input int n, input bit last, input bit xorpat, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        load_valid = 1'b0;
        tick();
        check("load_ready_gap", load_ready, 1);
      end
      load_valid = 1'b1;
      load_data  = xorpat ? (8'(i) ^ 8'hA5) : 8'($urandom);
      load_last  = last && (i == n - 1);
      model[i]   = load_data;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (last && n < 256)
      for (int j = n; j < 256; j++) model[j] = 8'h00;
    if (n == 256) check("busy_after_full_stream", busy, 0);
    else          check("busy_after_partial_stream", busy, 1);
  endtask

  task automatic wait_run(input int exp_cycles);
    int cyc = 0;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
    end
    check("fill_cycles", cyc, exp_cycles);
    check("busy_in_run", busy, 0);
  endtask

  task automatic lookup(input logic [7:0] idx);
    lkp_valid = 1'b1;
    lkp_index = idx;
    exp_ba    = model[idx];
    tick();
    lkp_valid = 1'b0;
    check("lookup_valid", addr_valid, 1);
    check("lookup_data", branch_addr, exp_ba);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    exp_ba = 8'h00;
    check("rst_busy", busy, 1);
    check("rst_load_ready", load_ready, 1);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_branch_addr", branch_addr, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_upd_ready", upd_ready, 0);
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Random RUN traffic with held update requests and colliding indices.
  task automatic random_run(input int ncyc);
    bit         pend = 1'b0;
    logic [7:0] ui = 8'h0;
    logic [7:0] ud = 8'h0;
    for (int c = 0; c < ncyc; c++) begin
      logic       lv;
      logic [7:0] li;
      lv = ($urandom % 3 == 0);
      li = 8'($urandom % 8);
      if (!pend && ($urandom % 2 == 1)) begin
        pend = 1'b1;
        ui   = 8'($urandom % 8);
        ud   = 8'($urandom);
      end
      lkp_valid = lv;
      lkp_index = li;
      upd_valid = pend;
      upd_index = ui;
      upd_data  = ud;
      #1;
      check("rand_upd_ready", upd_ready, {31'b0, !lv});
      if (lv) exp_ba = model[li];
      if (pend && !lv) begin
        model[ui] = ud;
        pend      = 1'b0;
      end
      tick();
      check("rand_addr_valid", addr_valid, {31'b0, lv});
      check("rand_branch_addr", branch_addr, exp_ba);
    end
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    tick();
  endtask

  initial begin
    Reset      = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    reload     = 1'b0;
    lkp_valid  = 1'b0;
    lkp_index  = '0;
    upd_valid  = 1'b0;
    upd_index  = '0;
    upd_data   = '0;
    repeat (2) @(posedge Clk);
    do_reset();

    // Full 256-byte boot load of i ^ 0xA5.
    stream(256, 1'b0, 1'b1, 1'b0);
    check("run_load_ready", load_ready, 0);
    lookup(8'd3);
    check("lookup3_value", branch_addr, 8'hA6);
    tick();
    check("addr_valid_idle", addr_valid, 0);
    check("branch_addr_hold", branch_addr, 8'hA6);

    // Short stream then zero fill.
    do_reset();
    stream(5, 1'b1, 1'b0, 1'b0);
    check("fill_load_ready", load_ready, 0);
    wait_run(251);
    lookup(8'd200);
    lookup(8'd4);
    lookup(8'd0);

    // Lookup and update to the same index in one cycle.
    lkp_valid = 1'b1;
    lkp_index = 8'd7;
    upd_valid = 1'b1;
    upd_index = 8'd7;
    upd_data  = 8'h3C;
    #1;
    check("collide_upd_ready", upd_ready, 0);
    exp_ba = model[7];
    tick();
    check("collide_addr_valid", addr_valid, 1);
    check("collide_old_value", branch_addr, exp_ba);
    lkp_valid = 1'b0;
    #1;
    check("deferred_upd_ready", upd_ready, 1);
    model[7] = 8'h3C;
    tick();
    upd_valid = 1'b0;
    lookup(8'd7);
    check("updated_value", branch_addr, 8'h3C);

    random_run(300);

    // Reset during RUN right after a lookup, and again mid-load.
    lookup(8'd6);
    do_reset();
    stream(100, 1'b0, 1'b0, 1'b1);
    do_reset();
    stream(256, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) lookup(8'($urandom));
    lookup(8'd255);

    // Reload together with a lookup: lookup completes, then stall.
    lkp_valid = 1'b1;
    lkp_index = 8'd10;
    reload    = 1'b1;
    exp_ba    = model[10];
    tick();
    reload    = 1'b0;
    check("reload_lookup_valid", addr_valid, 1);
    check("reload_lookup_data", branch_addr, exp_ba);
    check("reload_busy", busy, 1);
    check("reload_load_ready", load_ready, 1);
    lkp_index = 8'd20;
    tick();
    lkp_valid = 1'b0;
    check("load_lookup_ignored", addr_valid, 0);
    check("load_lookup_hold", branch_addr, exp_ba);
    stream(40, 1'b1, 1'b0, 1'b1);
    wait_run(216);
    random_run(200);
    lookup(8'd39);
    lookup(8'd40);

`ifdef BRANCH_LUT_PARITY_EN
    lookup(8'd9);
    check("parity_clean", parity_err, 0);
    dut.u_ram.mem[9] = {^model[9], model[9] ^ 8'h01};
    model[9] = model[9] ^ 8'h01;
    lookup(8'd9);
    check("parity_err_set", parity_err, 1);
    lookup(8'd11);
    check("parity_err_sticky", parity_err, 1);
`else
    lookup(8'd9);
    check("parity_err_tied", parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
